// File: rtl/pipe_pkg.sv
// pipe_pkg: shared occupancy states and standard ID/EX bundle layout for elastic pipeline stages
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  localparam int IDEX_CTRL_W = 24;
  localparam int IDEX_DATA_W = 192;
  localparam int CTRL_REGWR = 0;
  localparam int CTRL_MEMWR = 1;
  localparam int CTRL_BRANCH = 2;
  localparam int CTRL_ALUCTR_LSB = 3;
  localparam int CTRL_ALUCTR_W = 4;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_ALUSRC = 8;
  localparam int CTRL_EXTOP = 9;
  localparam int DATA_BUSA_LSB = 0;
  localparam int DATA_BUSB_LSB = 32;
  localparam int DATA_PC_LSB = 64;
  localparam int DATA_IMM16_LSB = 96;
  localparam int DATA_RT_LSB = 112;
  localparam int DATA_RD_LSB = 117;
  localparam int DATA_REG_W = 5;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : (inc && cnt != '1) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline register with optional skid buffer, flush and perf counters
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int DATA_W = IDEX_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  logic out_fire;
  assign out_fire = out_valid && out_ready;
  generate
    if (SKID != 0) begin : g_skid
      state_t state, nxt;
      logic rdy, in_fire;
      logic [CTRL_W-1:0] s_ctrl;
      logic [DATA_W-1:0] s_data;
      assign in_fire = in_valid && rdy;
      assign in_ready = rdy;
      assign out_valid = state != EMPTY;
      always_comb
        nxt = state == EMPTY ? (in_fire ? ONE : EMPTY) :
              state == ONE ? ((in_fire && !out_fire) ? TWO : (!in_fire && out_fire) ? EMPTY : ONE) :
              (out_fire ? ONE : TWO);
      // out_ctrl is cleared whenever the main register empties, so a bubble never carries control
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          state <= EMPTY;
          rdy <= 1'b1;
          out_ctrl <= '0;
          out_data <= '0;
          s_ctrl <= '0;
          s_data <= '0;
        end else if (flush) begin
          state <= EMPTY;
          rdy <= 1'b1;
          out_ctrl <= '0;
        end else begin
          state <= nxt;
          rdy <= nxt != TWO;
          if (in_fire && (state == EMPTY || out_fire)) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
          end else if (state == TWO && out_fire) begin
            out_ctrl <= s_ctrl;
            out_data <= s_data;
          end else if (out_fire) out_ctrl <= '0;
          if (in_fire && state == ONE && !out_fire) begin
            s_ctrl <= in_ctrl;
            s_data <= in_data;
          end
        end
    end else begin : g_reg
      logic v;
      assign in_ready = out_ready || !v;
      assign out_valid = v;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          v <= 1'b0;
          out_ctrl <= '0;
          out_data <= '0;
        end else if (flush) begin
          v <= 1'b0;
          out_ctrl <= '0;
        end else if (in_ready) begin
          v <= in_valid;
          out_ctrl <= in_valid ? in_ctrl : '0;
          if (in_valid) out_data <= in_data;
        end
    end
  endgenerate
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(clk), .rst_n(rst_n), .inc(out_valid && !out_ready), .clr(cnt_clr), .cnt(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_bubble (
    .clk(clk), .rst_n(rst_n), .inc(!out_valid), .clr(cnt_clr), .cnt(bubble_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: skid and non-skid stages driven in parallel, checked against queue models
module tb_pipe_stage_elastic;
  localparam int CW = 24;
  localparam int DW = 192;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready1, out_valid1, in_ready0, out_valid0;
  logic [CW-1:0] out_ctrl1, out_ctrl0;
  logic [DW-1:0] out_data1, out_data0;
  logic [15:0] stall1, bubble1;
  logic [3:0] stall0, bubble0;
  logic [CW+DW-1:0] q1[$], q0[$];
  logic r1 = 1'b1;
  int st1 = 0, bu1 = 0, st0 = 0, bu0 = 0, n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .cnt_clr(cnt_clr), .stall_cnt(stall1), .bubble_cnt(bubble1)
  );
  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .cnt_clr(cnt_clr), .stall_cnt(stall0), .bubble_cnt(bubble0)
  );
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic check_out();
    chk("s1_valid", 256'(out_valid1), 256'(q1.size() != 0));
    chk("s1_ctrl", 256'(out_ctrl1), q1.size() != 0 ? 256'(q1[0][CW+DW-1:DW]) : 256'(0));
    if (q1.size() != 0) chk("s1_data", 256'(out_data1), 256'(q1[0][DW-1:0]));
    chk("s1_stall", 256'(stall1), 256'(st1));
    chk("s1_bubble", 256'(bubble1), 256'(bu1));
    chk("s0_valid", 256'(out_valid0), 256'(q0.size() != 0));
    chk("s0_ctrl", 256'(out_ctrl0), q0.size() != 0 ? 256'(q0[0][CW+DW-1:DW]) : 256'(0));
    if (q0.size() != 0) chk("s0_data", 256'(out_data0), 256'(q0[0][DW-1:0]));
    chk("s0_stall", 256'(stall0), 256'(st0));
    chk("s0_bubble", 256'(bubble0), 256'(bu0));
  endtask
  task automatic cycle(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                       input logic ordy, input logic fl, input logic clr);
    logic rdy0;
    in_valid = iv;
    in_ctrl = ic;
    in_data = id;
    out_ready = ordy;
    flush = fl;
    cnt_clr = clr;
    rdy0 = ordy || q0.size() == 0;
    #1;
    chk("s1_in_ready", 256'(in_ready1), 256'(r1));
    chk("s0_in_ready", 256'(in_ready0), 256'(rdy0));
    @(posedge clk);
    st1 = clr ? 0 : (q1.size() != 0 && !ordy && st1 < 65535) ? st1 + 1 : st1;
    bu1 = clr ? 0 : (q1.size() == 0 && bu1 < 65535) ? bu1 + 1 : bu1;
    st0 = clr ? 0 : (q0.size() != 0 && !ordy && st0 < 15) ? st0 + 1 : st0;
    bu0 = clr ? 0 : (q0.size() == 0 && bu0 < 15) ? bu0 + 1 : bu0;
    if (fl) begin
      q1.delete();
      q0.delete();
      r1 = 1'b1;
    end else begin
      if (q1.size() != 0 && ordy) void'(q1.pop_front());
      if (iv && r1) q1.push_back({ic, id});
      r1 = q1.size() < 2;
      if (q0.size() != 0 && ordy) void'(q0.pop_front());
      if (iv && rdy0) q0.push_back({ic, id});
    end
    #1;
    check_out();
  endtask
  task automatic check_reset();
    chk("rst_s1_valid", 256'(out_valid1), 256'(0));
    chk("rst_s1_ctrl", 256'(out_ctrl1), 256'(0));
    chk("rst_s1_data", 256'(out_data1), 256'(0));
    chk("rst_s1_in_ready", 256'(in_ready1), 256'(1));
    chk("rst_s1_cnts", 256'({stall1, bubble1}), 256'(0));
    chk("rst_s0_valid", 256'(out_valid0), 256'(0));
    chk("rst_s0_ctrl_data", 256'({out_ctrl0, out_data0}), 256'(0));
    chk("rst_s0_cnts", 256'({stall0, bubble0}), 256'(0));
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    cnt_clr = 1'b0;
    #1;
    check_reset();
    q1.delete();
    q0.delete();
    r1 = 1'b1;
    st1 = 0;
    bu1 = 0;
    st0 = 0;
    bu0 = 0;
    #1 rst_n = 1'b1;
  endtask
  initial begin
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    #12;
    check_reset();
    #1 rst_n = 1'b1;
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("bubble_before_arrival", 256'(bubble1), 256'(1));
    cycle(1'b1, 24'h00A5A5, 192'h1234, 1'b1, 1'b0, 1'b0);
    chk("first_beat_valid", 256'(out_valid1), 256'(1));
    chk("first_beat_ctrl", 256'(out_ctrl1), 256'(24'h00A5A5));
    chk("first_beat_data", 256'(out_data1), 256'(192'h1234));
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 2; i++) cycle(1'b1, 24'(i), 192'(i), 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", 256'(in_ready1), 256'(0));
    for (int i = 0; i < 3; i++) cycle(1'b1, 24'(3), 192'(3), i != 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 24'($urandom), rnd_data(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 24'hFFFFFF, '1, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", 256'(out_valid1), 256'(0));
    chk("flush_ctrl", 256'(out_ctrl1), 256'(0));
    chk("flush_in_ready", 256'(in_ready1), 256'(1));
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 24'h5, 192'h55, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 24'h6, 192'h66, 1'b0, 1'b0, 1'b0);
    chk("s0_stall_saturated", 256'(stall0), 256'(15));
    cycle(1'b1, 24'h6, 192'h66, 1'b0, 1'b0, 1'b1);
    chk("s0_stall_cleared", 256'(stall0), 256'(0));
    for (int i = 0; i < 600; i++) begin
      c = 24'($urandom);
      d = rnd_data();
      cycle($urandom_range(0, 3) != 0, c, d, $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 24'($urandom), rnd_data(), 1'b0, 1'b0, 1'b0);
    chk("two_before_reset", 256'(in_ready1), 256'(0));
    async_reset();
    cycle(1'b1, 24'h0ABCDE, 192'hBEEF, 1'b1, 1'b0, 1'b0);
    chk("post_reset_latency", 256'({out_valid1, out_valid0}), 256'(2'b11));
    chk("post_reset_data", 256'(out_data1), 256'(192'hBEEF));
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
